keycode_midi_event_gen: RTL

- Parametrised successor to the keycode-to-MIDI lookup.
- Accepts full keyboard reports of NUMKEYS keycodes and diffs each report against the previously held set.
- Emits a buffered stream of MIDI note-on/note-off events with octave and signed transpose applied.
- Sits between the USB/PS2 keyboard front end and the FM voice allocator.

---
 rtl/keycode_midi_event_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/keycode_midi_event_gen.sv
// keycode_midi_event_gen: diffs keyboard reports into a buffered MIDI note-on/off event stream (option: EVENT_TIMESTAMP_EN)
module keycode_midi_event_gen #(
  parameter int NUMKEYS = 6,
  parameter int FIFO_DEPTH = 16,
  parameter logic [6:0] VELOCITY = 7'd100
) (
  input  logic clk,
  input  logic reset,
  input  logic report_valid,
  output logic report_ready,
  input  logic [7:0] keycodes [0:NUMKEYS-1],
  input  logic [2:0] octave,
  input  logic [5:0] transpose,
  output logic ev_valid,
  input  logic ev_ready,
  output logic ev_noteon,
  output logic [6:0] ev_note,
  output logic [6:0] ev_velocity,
  output logic [$clog2(NUMKEYS+1)-1:0] held_count,
  output logic rollover_err
`ifdef EVENT_TIMESTAMP_EN
  ,
  output logic [15:0] ev_timestamp
`endif
);
  localparam int CW = $clog2(NUMKEYS+1);
  localparam int IW = NUMKEYS > 1 ? $clog2(NUMKEYS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef EVENT_TIMESTAMP_EN
  localparam int EW = 24;
`else
  localparam int EW = 8;
`endif
  typedef enum logic [2:0] {IDLE, CHECK, SCAN_UP, SCAN_DN, COMMIT} state_t;
  state_t state, nstate;
  logic [IW-1:0] idx, nidx;
  logic [7:0] nk [0:NUMKEYS-1];
  logic [7:0] hk [0:NUMKEYS-1];
  logic [6:0] hn [0:NUMKEYS-1];
  logic [2:0] oct;
  logic [5:0] trn;
  logic [7:0] nc [0:NUMKEYS-1];
  logic [6:0] old_note [0:NUMKEYS-1];
  logic [7:0] nxt_key [0:NUMKEYS-1];
  logic [6:0] nxt_note [0:NUMKEYS-1];
  logic [NUMKEYS-1:0] dup, old_hit, new_hit;
  logic [CW-1:0] nxt_cnt;
  logic any_roll, push, push_do, pop, space, full, empty, rerr_set, ev_on;
  logic [6:0] ev_n;
  logic [AW:0] wp, rp;
  logic [EW-1:0] mem [0:FIFO_DEPTH-1];
  logic [EW-1:0] head, entry;
  function automatic logic [5:0] key_base(input logic [7:0] k);
    case (k)
      8'h04: return {1'b1, 5'd0};
      8'h1A: return {1'b1, 5'd1};
      8'h16: return {1'b1, 5'd2};
      8'h08: return {1'b1, 5'd3};
      8'h07: return {1'b1, 5'd4};
      8'h09: return {1'b1, 5'd5};
      8'h17: return {1'b1, 5'd6};
      8'h0A: return {1'b1, 5'd7};
      8'h1C: return {1'b1, 5'd8};
      8'h0B: return {1'b1, 5'd9};
      8'h18: return {1'b1, 5'd10};
      8'h0D: return {1'b1, 5'd11};
      8'h0E: return {1'b1, 5'd12};
      8'h12: return {1'b1, 5'd13};
      8'h0F: return {1'b1, 5'd14};
      8'h13: return {1'b1, 5'd15};
      8'h33: return {1'b1, 5'd16};
      default: return 6'd0;
    endcase
  endfunction
  // {in_range, note}; out-of-range or unmapped keys return in_range = 0
  function automatic logic [7:0] calc_note(input logic [7:0] k, input logic [2:0] o, input logic [5:0] t);
    logic [5:0] b;
    logic [6:0] m;
    logic signed [8:0] n;
    b = key_base(k);
    m = 7'(12 * (int'(o) + 1));
    n = $signed({4'b0, b[4:0]}) + $signed({2'b0, m}) + $signed({{3{t[5]}}, t});
    return {b[5] && n >= 0 && n <= 127, n[6:0]};
  endfunction
  always_comb begin
    any_roll = 1'b0;
    nxt_cnt = '0;
    for (int j = 0; j < NUMKEYS; j++) begin
      dup[j] = 1'b0;
      old_hit[j] = 1'b0;
      new_hit[j] = 1'b0;
      old_note[j] = '0;
      nc[j] = calc_note(nk[j], oct, trn);
      if (nk[j] == 8'h01) any_roll = 1'b1;
      for (int k = 0; k < NUMKEYS; k++) begin
        if (k < j && nk[k] == nk[j]) dup[j] = 1'b1;
        if (hk[k] != 8'h00 && hk[k] == nk[j]) begin
          old_hit[j] = 1'b1;
          old_note[j] = hn[k];
        end
        if (nk[k] == hk[j]) new_hit[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUMKEYS; j++) begin
      nxt_key[j] = (!dup[j] && (old_hit[j] || nc[j][7])) ? nk[j] : 8'h00;
      nxt_note[j] = old_hit[j] ? old_note[j] : nc[j][6:0];
      nxt_cnt = nxt_cnt + CW'(nxt_key[j] != 8'h00);
    end
  end
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = !empty && ev_ready;
  assign space = !full || ev_ready;
  assign push_do = push && space;
  assign report_ready = state == IDLE;
  always_comb begin
    nstate = state;
    nidx = idx;
    push = 1'b0;
    ev_on = 1'b0;
    ev_n = '0;
    rerr_set = 1'b0;
    case (state)
      IDLE: nstate = report_valid ? CHECK : IDLE;
      CHECK: begin
        rerr_set = any_roll;
        nstate = any_roll ? IDLE : SCAN_UP;
        nidx = '0;
      end
      SCAN_UP: begin
        push = hk[idx] != 8'h00 && !new_hit[idx];
        ev_n = hn[idx];
        if (!push || space) begin
          nstate = idx == IW'(NUMKEYS-1) ? SCAN_DN : SCAN_UP;
          nidx = idx == IW'(NUMKEYS-1) ? '0 : idx + 1'b1;
        end
      end
      SCAN_DN: begin
        push = nc[idx][7] && !old_hit[idx] && !dup[idx];
        ev_on = 1'b1;
        ev_n = nc[idx][6:0];
        if (!push || space) begin
          nstate = idx == IW'(NUMKEYS-1) ? COMMIT : SCAN_DN;
          nidx = idx == IW'(NUMKEYS-1) ? '0 : idx + 1'b1;
        end
      end
      COMMIT: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
`ifdef EVENT_TIMESTAMP_EN
  logic [15:0] ts;
  assign entry = {ts, ev_on, ev_n};
  assign ev_timestamp = head[23:8];
  always_ff @(posedge clk) ts <= reset ? 16'd0 : ts + 16'd1;
`else
  assign entry = {ev_on, ev_n};
`endif
  assign head = mem[rp[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_noteon = head[7];
  assign ev_note = head[6:0];
  assign ev_velocity = head[7] ? VELOCITY : 7'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      wp <= '0;
      rp <= '0;
      hk <= '{default: 8'h00};
      hn <= '{default: 7'd0};
      held_count <= '0;
      rollover_err <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      if (state == IDLE && report_valid) begin
        nk <= keycodes;
        oct <= octave;
        trn <= transpose;
      end
      if (rerr_set) rollover_err <= 1'b1;
      if (push_do) begin
        mem[wp[AW-1:0]] <= entry;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (state == COMMIT) begin
        hk <= nxt_key;
        hn <= nxt_note;
        held_count <= nxt_cnt;
      end
    end
  end
endmodule
